// File: rtl/muldiv_iter_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: multiply-class RUN exits once the remaining multiplier bits are zero.
module muldiv_iter_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iStart,
  input  logic [3:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iFlush,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  function automatic logic [WIDTH-1:0] cneg_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [W2-1:0] cneg_2w(input logic neg, input logic [W2-1:0] v);
    return neg ? -v : v;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // prod_q is the product accumulator, or {remainder, quotient} for divides
  logic [W2-1:0]    prod_q, mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             isdiv_q, acc_q, sub_q, neg_q, rneg_q, zdiv_q;

  logic             accept, start_md, is_div_op, div_zero_op, sgn, a_neg, b_neg, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept      = (state_q == S_IDLE) && iStart && !iFlush;
  assign start_md    = accept && !iOp[3];
  assign is_div_op   = (iOp[3:1] == 3'b001);
  assign div_zero_op = is_div_op && (iB == '0);
  assign sgn         = ~iOp[0];
  assign a_neg       = sgn & iA[WIDTH-1];
  assign b_neg       = sgn & iB[WIDTH-1];
  assign a_mag       = cneg_w(a_neg, iA);
  assign b_mag       = cneg_w(b_neg, iB);

`ifdef MULDIV_EARLY_OUT_EN
  assign last_iter = (cnt_q == CNT_W'(1)) || (!isdiv_q && (mplier_q[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt_q == CNT_W'(1));
`endif

  logic [W2-1:0]    prod_d, mcand_d;
  logic [WIDTH-1:0] mplier_d;
  logic [WIDTH:0]   rsh, rdiff;

  always_comb begin
    rsh      = {prod_q[W2-1:WIDTH], prod_q[WIDTH-1]};
    rdiff    = rsh - {1'b0, mcand_q[WIDTH-1:0]};
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
    if (isdiv_q) begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      // rdiff MSB is the borrow: set when the shifted remainder is below the divisor
      if (!rdiff[WIDTH]) prod_d = {rdiff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      else               prod_d = {rsh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end
  end

  logic [W2-1:0]    psg, res_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  always_comb begin
    psg = cneg_2w(neg_q, prod_q);
    if (zdiv_q)       res_d = prod_q;
    else if (isdiv_q) res_d = {cneg_w(rneg_q, prod_q[W2-1:WIDTH]), cneg_w(neg_q, prod_q[WIDTH-1:0])};
    else if (sub_q)   res_d = {hi_q, lo_q} - psg;
    else if (acc_q)   res_d = {hi_q, lo_q} + psg;
    else              res_d = psg;
    hi_d = res_d[W2-1:WIDTH];
    lo_d = res_d[WIDTH-1:0];
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept && !iOp[3]) begin
            busy_q  <= 1'b1;
            dz_q    <= 1'b0;
            cnt_q   <= CNT_W'(WIDTH);
            state_q <= div_zero_op ? S_FIX : S_RUN;
          end else if (accept && (iOp[3:1] == 3'b100)) begin
            done_q <= 1'b1;
            dz_q   <= 1'b0;
            if (iOp[0]) lo_q <= iA;
            else        hi_q <= iA;
          end
        end
        S_RUN: begin
          if (iFlush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_iter) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!iFlush) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b1;
            dz_q   <= zdiv_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath registers need no reset: they are always loaded before use
  always_ff @(posedge iCLK) begin
    if (start_md) begin
      isdiv_q  <= is_div_op;
      acc_q    <= iOp[2];
      sub_q    <= iOp[2] & iOp[1];
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      zdiv_q   <= div_zero_op;
      mcand_q  <= {{WIDTH{1'b0}}, is_div_op ? b_mag : a_mag};
      mplier_q <= b_mag;
      if (div_zero_op)    prod_q <= {iA, {WIDTH{1'b1}}};
      else if (is_div_op) prod_q <= {{WIDTH{1'b0}}, a_mag};
      else                prod_q <= '0;
    end else if (state_q == S_RUN) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oDivZero = dz_q;
  assign oHI      = hi_q;
  assign oLO      = lo_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit (WIDTH=32); fixed-latency checks apply only without MULDIV_EARLY_OUT_EN.
module tb_muldiv_iter_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_iter_unit #(.WIDTH(W)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iOp(op), .iA(a), .iB(b),
    .iFlush(flush), .oBusy(busy), .oDone(done), .oDivZero(dz), .oHI(hi), .oLO(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single edge (edge 0); returns just after that edge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  // Edges after edge 0 until oDone is seen; -1 if it never comes
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    issue(4'd8, 32'd5, 32'd0);
    n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL mthi_pre_reset: got %h expected %h", hi, 32'd5); end
    rst_n = 1'b0; tick(); tick();
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h expected 0", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL reset_divzero: got %b expected 0", dz); end
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    int  n;
    logic bad;
    issue(4'd0, 32'hFFFF_FFFD, 32'd7);
`ifndef MULDIV_EARLY_OUT_EN
    bad = 1'b0;
    if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL mult_busy_window: got glitch %b expected 0", bad); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_busy_end: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mult_done_edge33: got %b expected 1", done); end
`else
    wait_done(n);
    n_cmp++; if (n < 0) begin n_bad++; $display("FAIL mult_done_timeout: got %0d expected >0", n); end
`endif
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
    n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFF_FFEB); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_divide();
    int n;
    issue(4'd3, 32'hFFFF_FFFF, 32'd16);
    wait_done(n);
`ifndef MULDIV_EARLY_OUT_EN
    n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL divu_latency: got %0d expected 33", n); end
`endif
    n_cmp++; if (lo !== 32'h0FFF_FFFF) begin n_bad++; $display("FAIL divu_lo: got %h expected %h", lo, 32'h0FFF_FFFF); end
    n_cmp++; if (hi !== 32'h0000_000F) begin n_bad++; $display("FAIL divu_hi: got %h expected %h", hi, 32'hF); end
    issue(4'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_lo: got %h expected %h", lo, 32'h8000_0000); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL div_ovf_hi: got %h expected 0", hi); end
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL div_ovf_flag: got %b expected 0", dz); end
  endtask

  task automatic test_divzero();
    issue(4'd2, 32'd42, 32'd0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dz_busy: got %b expected 1", busy); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL dz_done: got %b expected 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dz_busy_end: got %b expected 0", busy); end
    n_cmp++; if (hi !== 32'd42) begin n_bad++; $display("FAIL dz_hi: got %h expected %h", hi, 32'd42); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_lo: got %h expected %h", lo, 32'hFFFF_FFFF); end
    n_cmp++; if (dz !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b expected 1", dz); end
    tick();
    n_cmp++; if (done !== 1'b0 || dz !== 1'b1) begin n_bad++; $display("FAIL dz_hold: got done=%b flag=%b expected 0/1", done, dz); end
    issue(4'd9, 32'd0, 32'd0);
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL mtlo_lo: got %h expected 0", lo); end
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL mtlo_clears_flag: got %b expected 0", dz); end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_handshake: got done=%b busy=%b expected 1/0", done, busy); end
  endtask

  task automatic test_accumulate();
    int n;
    issue(4'd8, 32'd0, 32'd0);
    issue(4'd9, 32'hFFFF_FFFF, 32'd0);
    issue(4'd5, 32'd1, 32'd1);
    wait_done(n);
`ifndef MULDIV_EARLY_OUT_EN
    n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL maddu_latency: got %0d expected 33", n); end
`endif
    n_cmp++; if (hi !== 32'd1 || lo !== 32'd0) begin n_bad++; $display("FAIL maddu: got %h_%h expected 00000001_00000000", hi, lo); end
    issue(4'd6, 32'd1, 32'd1);
    wait_done(n);
    n_cmp++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL msub: got %h_%h expected 00000000_ffffffff", hi, lo); end
    issue(4'd4, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    n_cmp++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL madd_neg: got %h_%h expected 00000000_fffffff9", hi, lo); end
  endtask

  task automatic test_flush();
    logic saw_done;
`ifdef MULDIV_EARLY_OUT_EN
    issue(4'd0, 32'd3, 32'h4000_0003);
`else
    issue(4'd0, 32'd3, 32'd3);
`endif
    for (int i = 1; i <= 4; i++) tick();
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd5;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_mid: got %b expected 1", busy); end
    for (int i = 6; i <= 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b expected 0", busy); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL flush_quiet: got activity %b expected 0", saw_done); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL flush_hilo: got %h_%h expected 00000000_fffffff9", hi, lo); end
  endtask

  task automatic test_idle_cases();
    issue(4'd12, 32'd77, 32'd1);
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL nop_handshake: got done=%b busy=%b expected 0/0", done, busy); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL nop_hilo: got %h_%h expected 00000000_fffffff9", hi, lo); end
    start = 1'b1; flush = 1'b1; op = 4'd8; a = 32'd1234;
    tick();
    start = 1'b0; flush = 1'b0;
    tick();
    n_cmp++; if (hi !== 32'd0 || done !== 1'b0) begin n_bad++; $display("FAIL idle_flush_blocks: got hi=%h done=%b expected 0/0", hi, done); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    n_cmp++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", hi, lo); end
    issue(4'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    n_cmp++; if (hi !== 32'h4000_0000 || lo !== 32'h0) begin n_bad++; $display("FAIL mult_minneg: got %h_%h expected 40000000_00000000", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divide();
    test_divzero();
    test_accumulate();
    test_flush();
    test_idle_cases();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle HI/LO multiply/divide path of the core ALU.
- Computes signed/unsigned multiply, divide, multiply-accumulate and multiply-subtract iteratively: one bit per cycle, radix-2 shift-add or restoring divide.
- Holds the architectural HI/LO pair and exposes start/busy/done handshake so the pipeline stalls on access.
- Sits beside the ALU in the EX stage; mfhi/mflo read oHI/oLO directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be even and >= 8.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- iCLK  in  1  clock
- iRST_N  in  1  synchronous active-low reset
- iStart  in  1  request; sampled only in IDLE
- iOp  in  4  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MADD 5=MADDU 6=MSUB 7=MSUBU 8=MTHI 9=MTLO; others are NOP
- iA  in  WIDTH  rs operand / dividend / MTHI-MTLO source
- iB  in  WIDTH  rt operand / divisor
- iFlush  in  1  abort in-flight operation (exception/branch squash)
- oBusy  out  1  operation in progress; pipeline stalls HI/LO readers
- oDone  out  1  one-cycle pulse when HI/LO hold the new result
- oDivZero  out  1  last accepted divide had a zero divisor
- oHI  out  WIDTH  HI register
- oLO  out  WIDTH  LO register

Behaviour:
- Reset: sampled on the rising edge while iRST_N=0. Sets HI=LO=0, oBusy=0, oDone=0, oDivZero=0 and state=IDLE. It aborts any operation mid-flight with no partial HI/LO update. Reset wins over iFlush and iStart.
- State machine:
  - IDLE -> RUN when iStart=1 and iOp is 0..7. Operands are latched and magnitudes taken for signed ops; counter=WIDTH; oDivZero is cleared.
  - RUN: one iteration per cycle; counter decrements; at counter==1 -> FIX.
  - FIX: applies sign correction, accumulate/subtract, and writes HI/LO at the end of this cycle -> IDLE.
- Latency, start accepted at edge 0:
  - HI/LO updated at edge WIDTH+1.
  - oBusy=1 from edge 0 until edge WIDTH+1.
  - oDone=1 for exactly one cycle after edge WIDTH+1.
- MTHI/MTLO: accepted in IDLE. HI (or LO) := iA at the accepting edge; oDone pulses the next cycle; oBusy stays 0.
- NOP opcodes with iStart=1: no effect, no oDone.
- iStart while oBusy=1: ignored; no queueing.
- MULT/MULTU: {HI,LO} := full 2*WIDTH-bit product.
- MADD/MADDU/MSUB/MSUBU: {HI,LO} := {HI,LO} ± product, modulo 2^(2*WIDTH). The old {HI,LO} is the value at FIX, which equals the value at start because HI/LO are frozen while busy.
- DIV/DIVU: LO := quotient truncated toward zero; HI := remainder with the sign of the dividend. DIV of most-negative by -1 gives LO=most-negative, HI=0, no flag.
- Divide by zero: detected at acceptance. Skips RUN and goes straight to FIX (HI/LO written at edge 1, oDone after edge 1). Result is HI:=iA, LO:=all ones, oDivZero:=1. oDivZero holds until the next accepted operation.
- iFlush=1 in RUN or FIX: return to IDLE at that edge; HI/LO unchanged, no oDone, oBusy=0 next cycle. iFlush in IDLE blocks acceptance of a same-cycle iStart.
- Signed correction: product is negated iff the operand signs differ; quotient negated iff the signs differ; remainder negated iff the dividend is negative.

Optional Feature:
- MULDIV_EARLY_OUT_EN
  - Defined: in a multiply-class RUN, when the remaining shifted multiplier bits are all zero, go to FIX at the next edge. Latency becomes (index of the highest set magnitude bit + 2) edges, minimum 2 for a zero or one-bit multiplier. Divide latency is unchanged.
  - Undefined: fixed WIDTH+1 latency for all non-zero-divisor operations.
- Benches must check oDone rather than count cycles when the macro is defined.

Test Plan:
- Reset/idle: hold iRST_N=0 two cycles after writing MTHI 5 -> oHI=0, oLO=0, oBusy=0, oDone=0.
- Signed multiply (WIDTH=32, macro off): MULT iA=-3, iB=7 -> at edge 33 HI=0xFFFFFFFF, LO=0xFFFFFFEB; oDone high one cycle; oBusy high edges 0..32.
- Unsigned divide and signed divide: DIVU 0xFFFFFFFF/16 -> LO=0x0FFFFFFF, HI=0xF. DIV -7/2 -> LO=-3, HI=-1.
- Divide by zero: DIV iA=42, iB=0 -> oDone after edge 1; HI=42, LO=0xFFFFFFFF, oDivZero=1. A following MTLO 0 clears oDivZero.
- Accumulate: MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1×1 -> HI=1, LO=0. Then MSUB 1×1 -> HI=0, LO=0xFFFFFFFF.
- Flush/ignore: start MULT 3×3; iStart with DIVU at cycle 5 is ignored; iFlush at cycle 10 -> oBusy=0 next cycle, HI/LO unchanged, no oDone.
